// File: rtl/mult_rr_arbiter.sv
// Unsigned N x N -> 2N array multiplier built from unrolled shift-and-add rows.
// Latency: combinational.
// Backpressure: none; the output follows the operands directly.
module array_multiplier_Nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  logic [2*N-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) acc = acc + ({{N{1'b0}}, a} << i);
    end
  end

  assign p = acc;

endmodule

// Two-requester round-robin front-end around one shared combinational multiplier.
// Latency: operands accepted at edge k give rsp_valid after edge k+1.
// Backpressure: the response is held until rsp_ready; no operands are accepted meanwhile.
module mult_rr_arbiter #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_p,
  output logic           rsp_id,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic           ptr;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           op_id;
  logic           gnt0;
  logic           gnt1;
  logic [2*N-1:0] prod;

  // ptr only breaks ties; a lone valid requester is always granted.
  assign gnt0 = req0_valid && (!req1_valid || !ptr);
  assign gnt1 = req1_valid && (!req0_valid || ptr);

  assign req0_ready = (state == IDLE) && gnt0;
  assign req1_ready = (state == IDLE) && gnt1;
  assign busy       = (state != IDLE);

  array_multiplier_Nbit #(.N(N)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid && req0_ready) begin
            op_a  <= req0_a;
            op_b  <= req0_b;
            op_id <= 1'b0;
            ptr   <= 1'b1;
            state <= CALC;
          end else if (req1_valid && req1_ready) begin
            op_a  <= req1_a;
            op_b  <= req1_b;
            op_id <= 1'b1;
            ptr   <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          rsp_p     <= prod;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // rsp_p and rsp_id keep their last values after the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Scoreboard bench for mult_rr_arbiter: per-requester expected-product queues plus a
// transaction-level grant/busy model checked every cycle on the falling edge.
module tb_mult_rr_arbiter;

  localparam int N   = 4;
  localparam int LIM = 100;

  logic           clk;
  logic           rst_n;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           rsp_valid, rsp_ready, rsp_id, busy;
  logic [2*N-1:0] rsp_p;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   due   = -1;
  int   n_rsp = 0;
  logic m_busy = 1'b0;
  logic m_ptr  = 1'b0;
  logic m_id   = 1'b0;
  logic mg0, mg1;
  logic held   = 1'b0;
  logic [2*N-1:0] hp;
  logic           hid;
  logic [2*N-1:0] q0[$];
  logic [2*N-1:0] q1[$];
  bit             rsp_log[$];

  mult_rr_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_p      (rsp_p),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: grant/busy model, latency, hold-stability and response scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      chk("busy", busy, m_busy);
      mg0 = !m_busy && req0_valid && (!req1_valid || !m_ptr);
      mg1 = !m_busy && req1_valid && (!req0_valid || m_ptr);
      chk("req0_ready", req0_ready, mg0);
      chk("req1_ready", req1_ready, mg1);
      if (!m_busy) chk("rsp_valid_idle", rsp_valid, 0);
      if (cyc == due) chk("latency", rsp_valid, 1);
      if (held) begin
        chk("hold_vld", rsp_valid, 1);
        chk("hold_p", rsp_p, hp);
        chk("hold_id", rsp_id, hid);
      end
      held = m_busy && rsp_valid && !rsp_ready;
      hp   = rsp_p;
      hid  = rsp_id;
      if (m_busy && rsp_valid && rsp_ready) begin
        n_rsp++;
        rsp_log.push_back(rsp_id);
        chk("rsp_id", rsp_id, m_id);
        if (rsp_id == 1'b0) begin
          chk("q0_has_entry", q0.size() != 0, 1);
          if (q0.size() != 0) chk("rsp_p0", rsp_p, q0.pop_front());
        end else begin
          chk("q1_has_entry", q1.size() != 0, 1);
          if (q1.size() != 0) chk("rsp_p1", rsp_p, q1.pop_front());
        end
        m_busy = 1'b0;
      end else if (mg0 || mg1) begin
        m_busy = 1'b1;
        m_ptr  = mg0;
        m_id   = mg1;
        due    = cyc + 2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input int a, input int b, input int exp);
    bit got = 1'b0;
    if (id == 0) begin
      q0.push_back((2*N)'(exp));
      req0_a = N'(a); req0_b = N'(b); req0_valid = 1'b1;
    end else begin
      q1.push_back((2*N)'(exp));
      req1_a = N'(a); req1_b = N'(b); req1_valid = 1'b1;
    end
    for (int i = 0; i < LIM && !got; i++) begin
      @(negedge clk);
      got = (id == 0) ? req0_ready : req1_ready;
    end
    chk("send_accepted", got, 1);
    if (got) step();
    // Scramble the operand bus after the transfer; captured values must not follow.
    if (id == 0) begin
      req0_valid = 1'b0; req0_a = N'($urandom); req0_b = N'($urandom);
    end else begin
      req1_valid = 1'b0; req1_a = N'($urandom); req1_b = N'($urandom);
    end
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int i = 0; i < LIM && !idle; i++) begin
      idle = !m_busy && q0.size() == 0 && q1.size() == 0;
      if (!idle) step();
    end
    chk("drain_done", idle, 1);
  endtask

  // Called at posedge+1; leaves reset released before the next falling edge.
  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_p", rsp_p, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    m_busy = 1'b0; m_ptr = 1'b0; m_id = 1'b0;
    held = 1'b0; due = -1;
    q0.delete(); q1.delete();
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int n0;
    bit done0, done1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    step();
    do_reset();

    // Single request
    send(0, 3, 5, 15);
    drain();
    chk("t1_p", rsp_p, 15);
    chk("t1_id", rsp_id, 0);

    // Simultaneous requests from reset, then re-issue to confirm alternation
    step();
    do_reset();
    fork
      send(0, 15, 15, 225);
      send(1, 10, 3, 30);
    join
    drain();
    chk("t2_first_id", rsp_log[rsp_log.size()-2], 0);
    chk("t2_second_id", rsp_log[rsp_log.size()-1], 1);
    fork
      send(0, 15, 15, 225);
      send(1, 10, 3, 30);
    join
    drain();
    chk("t2b_first_id", rsp_log[rsp_log.size()-2], 0);
    chk("t2b_second_id", rsp_log[rsp_log.size()-1], 1);

    // Backpressure with a waiting req0
    rsp_ready = 1'b0;
    send(1, 9, 9, 81);
    fork
      send(0, 2, 7, 14);
      begin
        repeat (6) step();
        chk("bp_vld", rsp_valid, 1);
        chk("bp_p", rsp_p, 81);
        chk("bp_id", rsp_id, 1);
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("bp_after_id", rsp_log[rsp_log.size()-1], 0);

    // Zero and boundary operands
    send(0, 0, 15, 0);
    send(1, 15, 0, 0);
    send(0, 1, 15, 15);
    send(1, 15, 15, 225);
    drain();
    chk("bnd_last_p", rsp_p, 225);

    // Reset while in CALC, then while in DONE
    send(0, 5, 5, 25);
    do_reset();
    rsp_ready = 1'b0;
    send(0, 6, 6, 36);
    step();
    chk("pre_rst_done_vld", rsp_valid, 1);
    do_reset();
    rsp_ready = 1'b1;
    send(1, 10, 3, 30);
    drain();
    chk("post_rst_p", rsp_p, 30);
    chk("post_rst_id", rsp_id, 1);

    // Randomised stress: 500 transactions
    n0 = n_rsp;
    done0 = 1'b0;
    done1 = 1'b0;
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          int a, b;
          repeat ($urandom_range(0, 3)) step();
          a = $urandom_range(0, 15);
          b = $urandom_range(0, 15);
          send(0, a, b, a * b);
        end
        done0 = 1'b1;
      end
      begin
        for (int i = 0; i < 250; i++) begin
          int a, b;
          repeat ($urandom_range(0, 3)) step();
          a = $urandom_range(0, 15);
          b = $urandom_range(0, 15);
          send(1, a, b, a * b);
        end
        done1 = 1'b1;
      end
      begin
        while (!(done0 && done1)) begin
          step();
          rsp_ready = 1'($urandom_range(0, 1));
        end
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("rand_rsp_count", n_rsp - n0, 500);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
